// File: rtl/asrv32_pipeline_ctrl_pkg.sv
// Shared encodings for the ASRV32 pipeline controller: FSM states, stage indices
// (so per-stage stall/flush strobes can later be collected into a bus) and counter widths.
package asrv32_pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_MEM_WAIT = 2'd1,
    PCTRL_DRAIN    = 2'd2
  } pctrl_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Sized for the largest legal P_MEM_TIMEOUT (255) and P_TRAP_DRAIN (15).
  localparam int TMO_CNT_W   = 8;
  localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/asrv32_hazard_detect.sv
// Load-use comparator between the load in EX and the instruction in ID.
// Purely combinational, zero latency; x0 is never a real dependency.
module asrv32_hazard_detect (
  input  logic       i_valid_id,
  input  logic [4:0] i_rs1_addr_id,
  input  logic [4:0] i_rs2_addr_id,
  input  logic       i_valid_ex,
  input  logic       i_load_ex,
  input  logic [4:0] i_rd_addr_ex,
  output logic       o_load_use
);

  logic rd_nonzero;
  logic rs_match;

  assign rd_nonzero = (i_rd_addr_ex != 5'd0);
  assign rs_match   = (i_rd_addr_ex == i_rs1_addr_id) | (i_rd_addr_ex == i_rs2_addr_id);
  assign o_load_use = i_valid_ex & i_load_ex & i_valid_id & rd_nonzero & rs_match;

endmodule

// File: rtl/asrv32_pipeline_ctrl.sv
// Central hazard/sequencing controller: per-stage stall/flush strobes are combinational
// from registered state plus current inputs; state, counters and the timeout pulse are registered.
module asrv32_pipeline_ctrl
  import asrv32_pipeline_ctrl_pkg::*;
#(
  parameter int P_TRAP_DRAIN  = 2,
  parameter int P_MEM_TIMEOUT = 64,
  parameter int P_CNT_WIDTH   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid_id,
  input  logic [4:0]             i_rs1_addr_id,
  input  logic [4:0]             i_rs2_addr_id,
  input  logic                   i_valid_ex,
  input  logic                   i_load_ex,
  input  logic [4:0]             i_rd_addr_ex,
  input  logic                   i_redirect_ex,
  input  logic                   i_trap_wb,
  input  logic                   i_mret_wb,
  input  logic                   i_mem_busy,
  output logic                   o_stall_if,
  output logic                   o_stall_id,
  output logic                   o_stall_ex,
  output logic                   o_stall_mem,
  output logic                   o_flush_id,
  output logic                   o_flush_ex,
  output logic                   o_flush_mem,
  output logic                   o_mem_timeout,
  output logic [1:0]             o_state,
  output logic [P_CNT_WIDTH-1:0] o_stall_cycles
);

  localparam logic [TMO_CNT_W-1:0]   TMO_LAST   = TMO_CNT_W'(P_MEM_TIMEOUT - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(P_TRAP_DRAIN - 1);
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE    = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

  pctrl_state_e               state_q;
  logic [TMO_CNT_W-1:0]       tmo_cnt_q;
  logic [DRAIN_CNT_W-1:0]     drain_cnt_q;
  logic                       mem_timeout_q;
  logic [P_CNT_WIDTH-1:0]     stall_cycles_q;

  logic load_use;
  logic trap_evt;
  logic in_drain;
  logic tmo_hit;

  asrv32_hazard_detect u_hazard_detect (
    .i_valid_id    (i_valid_id),
    .i_rs1_addr_id (i_rs1_addr_id),
    .i_rs2_addr_id (i_rs2_addr_id),
    .i_valid_ex    (i_valid_ex),
    .i_load_ex     (i_load_ex),
    .i_rd_addr_ex  (i_rd_addr_ex),
    .o_load_use    (load_use)
  );

  assign trap_evt = i_trap_wb | i_mret_wb;
  assign in_drain = (state_q == PCTRL_DRAIN);
  // Busy still high on the last allowed wait cycle: abandon the access this cycle.
  assign tmo_hit  = (state_q == PCTRL_MEM_WAIT) & i_mem_busy & (tmo_cnt_q == TMO_LAST);

  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_stall_ex  = 1'b0;
    o_stall_mem = 1'b0;
    o_flush_id  = 1'b0;
    o_flush_ex  = 1'b0;
    o_flush_mem = 1'b0;
    if (i_rst) begin
      o_flush_id  = 1'b1;
      o_flush_ex  = 1'b1;
      o_flush_mem = 1'b1;
    end else if (trap_evt) begin
      o_flush_id  = 1'b1;
      o_flush_ex  = 1'b1;
      o_flush_mem = 1'b1;
    end else if (in_drain) begin
      o_flush_id  = 1'b1;
    end else if (i_mem_busy) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      if (tmo_hit) begin
        o_flush_ex  = 1'b1;
        o_flush_mem = 1'b1;
      end else begin
        o_stall_ex  = 1'b1;
        o_stall_mem = 1'b1;
      end
    end else if (i_redirect_ex) begin
      // A colliding load-use is moot: the dependent instruction is being flushed.
      o_flush_id  = 1'b1;
      o_flush_ex  = 1'b1;
    end else if (load_use) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_flush_ex  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= PCTRL_RUN;
      tmo_cnt_q      <= '0;
      drain_cnt_q    <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      mem_timeout_q <= 1'b0;
      if (o_stall_if) begin
        stall_cycles_q <= stall_cycles_q + CNT_ONE;
      end
      if (trap_evt) begin
        state_q     <= PCTRL_DRAIN;
        drain_cnt_q <= DRAIN_LOAD;
        tmo_cnt_q   <= '0;
      end else begin
        case (state_q)
          PCTRL_DRAIN: begin
            if (drain_cnt_q == '0) begin
              state_q <= PCTRL_RUN;
            end else begin
              drain_cnt_q <= drain_cnt_q - 1'b1;
            end
          end
          PCTRL_MEM_WAIT: begin
            if (!i_mem_busy) begin
              state_q   <= PCTRL_RUN;
              tmo_cnt_q <= '0;
            end else if (tmo_hit) begin
              state_q       <= PCTRL_DRAIN;
              drain_cnt_q   <= DRAIN_LOAD;
              tmo_cnt_q     <= '0;
              mem_timeout_q <= 1'b1;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
          end
          default: begin
            // The counter tracks consecutive busy cycles, so the entry cycle counts as one.
            if (i_mem_busy) begin
              state_q   <= PCTRL_MEM_WAIT;
              tmo_cnt_q <= TMO_CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign o_mem_timeout  = mem_timeout_q & ~i_rst;
  assign o_state        = state_q;
  assign o_stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_asrv32_pipeline_ctrl.sv
// Directed bench: each cycle pushes the expected strobes/state/counter into a queue;
// a negedge monitor pops and checks them against the DUT.
module tb_asrv32_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        valid_id;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        valid_ex;
  logic        load_ex;
  logic [4:0]  rd;
  logic        redirect;
  logic        trap;
  logic        mret;
  logic        busy;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_mem;
  logic        mem_timeout;
  logic [1:0]  state;
  logic [31:0] stall_cycles;

  asrv32_pipeline_ctrl #(
    .P_TRAP_DRAIN  (2),
    .P_MEM_TIMEOUT (8),
    .P_CNT_WIDTH   (32)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid_id     (valid_id),
    .i_rs1_addr_id  (rs1),
    .i_rs2_addr_id  (rs2),
    .i_valid_ex     (valid_ex),
    .i_load_ex      (load_ex),
    .i_rd_addr_ex   (rd),
    .i_redirect_ex  (redirect),
    .i_trap_wb      (trap),
    .i_mret_wb      (mret),
    .i_mem_busy     (busy),
    .o_stall_if     (stall_if),
    .o_stall_id     (stall_id),
    .o_stall_ex     (stall_ex),
    .o_stall_mem    (stall_mem),
    .o_flush_id     (flush_id),
    .o_flush_ex     (flush_ex),
    .o_flush_mem    (flush_mem),
    .o_mem_timeout  (mem_timeout),
    .o_state        (state),
    .o_stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  st;   // {if,id,ex,mem}
    logic [2:0]  fl;   // {id,ex,mem}
    logic        tmo;
    logic [1:0]  state;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_cnt = 0;
  logic [3:0]  obs_st;
  logic [2:0]  obs_fl;

  assign obs_st = {stall_if, stall_id, stall_ex, stall_mem};
  assign obs_fl = {flush_id, flush_ex, flush_mem};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++;
      assert (obs_st === mon_e.st) else begin
        bad++; $error("FAIL %s stall got=%b exp=%b", mon_e.tag, obs_st, mon_e.st);
      end
      total++;
      assert (obs_fl === mon_e.fl) else begin
        bad++; $error("FAIL %s flush got=%b exp=%b", mon_e.tag, obs_fl, mon_e.fl);
      end
      total++;
      assert (mem_timeout === mon_e.tmo) else begin
        bad++; $error("FAIL %s timeout got=%b exp=%b", mon_e.tag, mem_timeout, mon_e.tmo);
      end
      total++;
      assert (state === mon_e.state) else begin
        bad++; $error("FAIL %s state got=%0d exp=%0d", mon_e.tag, state, mon_e.state);
      end
      total++;
      assert (stall_cycles === mon_e.cnt) else begin
        bad++; $error("FAIL %s stall_cycles got=%0d exp=%0d", mon_e.tag, stall_cycles, mon_e.cnt);
      end
    end
  end

  task automatic idle();
    valid_id = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    valid_ex = 1'b0; load_ex = 1'b0; rd = 5'd0;
    redirect = 1'b0; trap = 1'b0; mret = 1'b0; busy = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [4:0] r_s2);
    valid_ex = 1'b1; load_ex = 1'b1; rd = r_d;
    valid_id = 1'b1; rs1 = r_s1; rs2 = r_s2;
  endtask

  // Called with inputs already driven for this cycle; records the expectation,
  // advances the stall-cycle model and moves on to the next cycle.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [2:0] ef,
                     input logic et, input logic [1:0] est);
    exp_t e;
    e.tag = tag; e.st = es; e.fl = ef; e.tmo = et; e.state = est; e.cnt = model_cnt;
    sb.push_back(e);
    if (rst) model_cnt = 0;
    else if (es[3]) model_cnt = model_cnt + 1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); #1;

    cyc("rst0", 4'b0000, 3'b111, 1'b0, 2'd0);
    cyc("rst1", 4'b0000, 3'b111, 1'b0, 2'd0);
    rst = 1'b0;
    cyc("idle", 4'b0000, 3'b000, 1'b0, 2'd0);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    load_use(5'd5, 5'd5, 5'd1);
    cyc("lu_rs1", 4'b1100, 3'b010, 1'b0, 2'd0);
    idle(); valid_ex = 1'b1; rd = 5'd5;
    cyc("lu_clear", 4'b0000, 3'b000, 1'b0, 2'd0);
    load_use(5'd7, 5'd2, 5'd7);
    cyc("lu_rs2", 4'b1100, 3'b010, 1'b0, 2'd0);
    load_use(5'd0, 5'd0, 5'd0);
    cyc("lu_x0", 4'b0000, 3'b000, 1'b0, 2'd0);
    load_use(5'd9, 5'd9, 5'd3); valid_id = 1'b0;
    cyc("lu_noid", 4'b0000, 3'b000, 1'b0, 2'd0);
    load_use(5'd9, 5'd9, 5'd3); load_ex = 1'b0;
    cyc("lu_noload", 4'b0000, 3'b000, 1'b0, 2'd0);

    // Redirect colliding with load-use
    load_use(5'd5, 5'd5, 5'd1); redirect = 1'b1;
    cyc("redir_lu", 4'b0000, 3'b110, 1'b0, 2'd0);
    idle();
    cyc("redir_after", 4'b0000, 3'b000, 1'b0, 2'd0);

    // Memory busy for 5 cycles; redirect/load-use ignored while busy
    busy = 1'b1;
    cyc("busy1", 4'b1111, 3'b000, 1'b0, 2'd0);
    cyc("busy2", 4'b1111, 3'b000, 1'b0, 2'd1);
    redirect = 1'b1;
    cyc("busy3", 4'b1111, 3'b000, 1'b0, 2'd1);
    redirect = 1'b0; load_use(5'd4, 5'd4, 5'd4);
    cyc("busy4", 4'b1111, 3'b000, 1'b0, 2'd1);
    idle(); busy = 1'b1;
    cyc("busy5", 4'b1111, 3'b000, 1'b0, 2'd1);
    busy = 1'b0;
    cyc("busy_rel", 4'b0000, 3'b000, 1'b0, 2'd1);
    cyc("busy_run", 4'b0000, 3'b000, 1'b0, 2'd0);

    // Busy stuck high: 8 busy cycles, timeout pulse on the 9th, then 2 DRAIN cycles
    busy = 1'b1;
    cyc("tmo_c1", 4'b1111, 3'b000, 1'b0, 2'd0);
    for (int i = 2; i <= 7; i++) cyc("tmo_wait", 4'b1111, 3'b000, 1'b0, 2'd1);
    cyc("tmo_c8", 4'b1100, 3'b011, 1'b0, 2'd1);
    busy = 1'b0;
    cyc("tmo_c9", 4'b0000, 3'b100, 1'b1, 2'd2);
    cyc("tmo_c10", 4'b0000, 3'b100, 1'b0, 2'd2);
    cyc("tmo_run", 4'b0000, 3'b000, 1'b0, 2'd0);

    // Trap during MEM_WAIT
    busy = 1'b1;
    cyc("tw_c1", 4'b1111, 3'b000, 1'b0, 2'd0);
    cyc("tw_c2", 4'b1111, 3'b000, 1'b0, 2'd1);
    cyc("tw_c3", 4'b1111, 3'b000, 1'b0, 2'd1);
    trap = 1'b1;
    cyc("tw_trap", 4'b0000, 3'b111, 1'b0, 2'd1);
    idle();
    cyc("tw_drain1", 4'b0000, 3'b100, 1'b0, 2'd2);
    cyc("tw_drain2", 4'b0000, 3'b100, 1'b0, 2'd2);
    for (int i = 0; i < 10; i++) cyc("tw_quiet", 4'b0000, 3'b000, 1'b0, 2'd0);

    // MRET, then a trap inside DRAIN reloads the drain counter
    mret = 1'b1;
    cyc("mret", 4'b0000, 3'b111, 1'b0, 2'd0);
    mret = 1'b0; trap = 1'b1;
    cyc("drain_trap", 4'b0000, 3'b111, 1'b0, 2'd2);
    trap = 1'b0; busy = 1'b1;
    cyc("reload1", 4'b0000, 3'b100, 1'b0, 2'd2);
    busy = 1'b0; redirect = 1'b1;
    cyc("reload2", 4'b0000, 3'b100, 1'b0, 2'd2);
    redirect = 1'b0;
    cyc("reload_run", 4'b0000, 3'b000, 1'b0, 2'd0);

    // Reset for one cycle mid-DRAIN
    trap = 1'b1;
    cyc("rd_trap", 4'b0000, 3'b111, 1'b0, 2'd0);
    trap = 1'b0; busy = 1'b1; rst = 1'b1;
    cyc("rd_rst", 4'b0000, 3'b111, 1'b0, 2'd2);
    rst = 1'b0; busy = 1'b0;
    cyc("rd_after", 4'b0000, 3'b000, 1'b0, 2'd0);
    cyc("rd_after2", 4'b0000, 3'b000, 1'b0, 2'd0);

    total++;
    assert (sb.size() == 0) else begin
      bad++; $error("FAIL sb_drain pending got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asrv32_pipeline_ctrl.md
Name: asrv32_pipeline_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage ASRV32 pipeline (IF, ID, EX, MEM, WB).
- Produces per-stage stall and flush strobes that drive the i_stall/i_flush inputs of each stage, including the decoder's.
- Detects load-use hazards between ID and EX, handles branch/jump redirects from EX, and handles traps/MRET from WB.
- Sequences multi-cycle data-memory waits with a timeout, and keeps a stall-cycle performance counter.

Parameters:
- P_TRAP_DRAIN, 2: cycles IF/ID stay flushed after a trap/MRET (CSR/PC settle); legal range 1..15.
- P_MEM_TIMEOUT, 64: consecutive i_mem_busy cycles before o_mem_timeout fires; legal range 2..255.
- P_CNT_WIDTH, 32: width of o_stall_cycles.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid_id  in  1  ID holds a valid instruction
- i_rs1_addr_id  in  5  rs1 of the instruction in ID
- i_rs2_addr_id  in  5  rs2 of the instruction in ID
- i_valid_ex  in  1  EX holds a valid instruction
- i_load_ex  in  1  instruction in EX is a load
- i_rd_addr_ex  in  5  rd of the instruction in EX
- i_redirect_ex  in  1  taken branch or JAL/JALR resolved in EX
- i_trap_wb  in  1  exception/interrupt taken in WB
- i_mret_wb  in  1  MRET retiring in WB
- i_mem_busy  in  1  data memory not ready for the access in MEM
- o_stall_if, o_stall_id, o_stall_ex, o_stall_mem  out  1 each  hold that stage's pipeline register
- o_flush_id, o_flush_ex, o_flush_mem  out  1 each  invalidate that stage's pipeline register (insert bubble)
- o_mem_timeout  out  1  one-cycle pulse: memory access fault
- o_state  out  2  FSM state, for debug
- o_stall_cycles  out  P_CNT_WIDTH  count of cycles with o_stall_if=1

Behaviour:
- Reset: i_rst is sampled on i_clk. While i_rst=1:
  - all o_stall_*=0; all o_flush_*=1; o_mem_timeout=0.
  - Next state is RUN; timeout and drain counters clear to 0; o_stall_cycles clears to 0.
  - Reset mid-wait or mid-drain aborts that sequence with no residual pulse.
- Timing: stall/flush outputs are combinational from the registered state and the current inputs (zero latency). State, counters and o_mem_timeout are registered.
- States: RUN=0, MEM_WAIT=1, DRAIN=2, code 3 unused (decodes as RUN).
- Priority each cycle: trap/mret > mem_busy > redirect > load-use.
- Trap/MRET, any state:
  - o_flush_id, o_flush_ex, o_flush_mem = 1.
  - Next state DRAIN; drain counter loads P_TRAP_DRAIN-1.
  - Overrides MEM_WAIT and clears the timeout counter.
- DRAIN:
  - o_flush_id=1; o_stall_*=0.
  - Counter decrements each cycle; exit to RUN when counter=0.
  - A new trap in DRAIN reloads the counter.
- Memory wait (RUN or MEM_WAIT, i_mem_busy=1):
  - o_stall_if/id/ex/mem = 1; o_flush_* = 0; redirect and load-use are ignored (EX re-presents them once released).
  - From RUN go to MEM_WAIT; timeout counter increments each MEM_WAIT cycle.
  - Counter reaching P_MEM_TIMEOUT-1 with busy still high:
    - o_mem_timeout=1 next cycle; next state DRAIN; o_flush_ex and o_flush_mem = 1 that cycle.
  - i_mem_busy=0 in MEM_WAIT: stalls drop the same cycle; next state RUN; counter cleared.
- Redirect (RUN, no busy): o_flush_id=1, o_flush_ex=1 for that cycle only; no state change.
- Load-use hazard in RUN:
  - Condition: i_valid_ex & i_load_ex & i_valid_id & rd!=0 & (rd==rs1 | rd==rs2), with rd = i_rd_addr_ex, rs1/rs2 = i_rs1_addr_id/i_rs2_addr_id.
  - Response: o_stall_if=1, o_stall_id=1, o_flush_ex=1 for exactly that cycle. The load then advances, so the hazard self-clears.
- Redirect with load-use: redirect only (the dependent instruction is flushed).
- o_stall_cycles: +1 on each cycle with o_stall_if=1 and i_rst=0; wraps modulo 2^P_CNT_WIDTH.

Decomposition:
- asrv32_header.vh gains:
  - state encodings PCTRL_RUN/PCTRL_MEM_WAIT/PCTRL_DRAIN;
  - stage index macros STG_IF..STG_WB, so stall/flush can later be bussed.
- One sub-module, asrv32_hazard_detect: pure combinational load-use comparator (rd/rs match, x0 exclusion). All sequencing stays in the top.

Test Plan:
- Load-use: lw x5 in EX, add x6,x5,x1 in ID → exactly one cycle of o_stall_if=o_stall_id=o_flush_ex=1; next cycle all 0. Repeat with rd=x0 → no stall.
- Redirect colliding with load-use in the same cycle → o_flush_id=o_flush_ex=1, o_stall_if=0.
- i_mem_busy high 5 cycles → o_stall_if..mem high exactly 5 cycles, o_state=1 for cycles 2-5, RUN after, o_stall_cycles=5.
- i_mem_busy stuck high, P_MEM_TIMEOUT=8 → o_mem_timeout single pulse at cycle 9, then DRAIN for P_TRAP_DRAIN cycles, then RUN.
- i_trap_wb pulse during MEM_WAIT → all three flushes the same cycle, o_flush_id held 2 cycles in DRAIN, timeout counter reset (no later timeout).
- i_rst asserted for 1 cycle mid-DRAIN → all flushes=1, stalls=0 that cycle; next cycle o_state=0, o_stall_cycles=0.
